// File: rtl/onewire_master_sequencer_if.sv
// onewire_master_sequencer_if: host command/response handshake plus the 1-Wire pull-low/sense pins.
// OW_CRC_EN adds the crc_out signal to both modports.
interface onewire_master_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       rsp_err;
    logic       busy;
    logic       bus_pull_low;
    logic       bus_in;
`ifdef OW_CRC_EN
    logic [7:0] crc_out;
    modport master (
        output cmd_valid, cmd_op, cmd_data, bus_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy, bus_pull_low, crc_out
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, bus_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy, bus_pull_low, crc_out
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_data, bus_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy, bus_pull_low
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, bus_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy, bus_pull_low
    );
`endif
endinterface

// File: rtl/onewire_master_sequencer.sv
// onewire_master_sequencer: byte-level 1-Wire RESET/WRITE_BYTE/READ_BYTE slot sequencer.
// OW_CRC_EN adds a running Dallas CRC-8 (poly 0x8C reflected) over every slot bit.
module onewire_master_sequencer #(
    parameter int CLK_PER_US = 50,
    parameter int T_RSTL     = 480,
    parameter int T_RSTH     = 480,
    parameter int T_PDS      = 70,
    parameter int T_SLOT     = 70,
    parameter int T_LOW1     = 6,
    parameter int T_LOW0     = 60,
    parameter int T_RDS      = 15
) (
    input logic clk,
    input logic reset,
    onewire_master_sequencer_if.slave ow
);
    typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, RST_HOLD, SLOT_LOW, SLOT_SAMP, SLOT_REC, DONE} state_t;
    localparam logic [31:0] L_RSTL  = 32'(T_RSTL * CLK_PER_US - 1);
    localparam logic [31:0] L_PDS   = 32'(T_PDS * CLK_PER_US - 1);
    localparam logic [31:0] L_HOLD  = 32'((T_RSTH - T_PDS) * CLK_PER_US - 1);
    localparam logic [31:0] L_LOW1  = 32'(T_LOW1 * CLK_PER_US - 1);
    localparam logic [31:0] L_LOW0  = 32'(T_LOW0 * CLK_PER_US - 1);
    localparam logic [31:0] L_SAMP  = 32'((T_RDS - T_LOW1) * CLK_PER_US - 1);
    localparam logic [31:0] L_RECRD = 32'((T_SLOT - T_RDS) * CLK_PER_US - 1);
    localparam logic [31:0] L_REC1  = 32'((T_SLOT - T_LOW1) * CLK_PER_US - 1);
    localparam logic [31:0] L_REC0  = 32'((T_SLOT - T_LOW0) * CLK_PER_US - 1);
    state_t      state;
    logic [31:0] timer;
    logic [2:0]  bit_cnt;
    logic [2:0]  nxt;
    logic [1:0]  op;
    logic [7:0]  sh;
    logic        presence_tmp;
    logic        rd_op;
    assign nxt          = bit_cnt + 3'd1;
    assign rd_op        = op == 2'b10;
    assign ow.cmd_ready = state == IDLE;
    assign ow.busy      = state != IDLE;
`ifdef OW_CRC_EN
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? 8'h8C : 8'h00);
    endfunction
`endif
    // sh holds the write byte and is overwritten bit by bit with read samples
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            bit_cnt         <= '0;
            op              <= '0;
            sh              <= '0;
            presence_tmp    <= 1'b0;
            ow.bus_pull_low <= 1'b0;
            ow.rsp_valid    <= 1'b0;
            ow.rsp_data     <= '0;
            ow.rsp_presence <= 1'b0;
            ow.rsp_err      <= 1'b0;
`ifdef OW_CRC_EN
            ow.crc_out      <= '0;
`endif
        end else begin
            ow.rsp_valid <= 1'b0;
            if (timer != '0) timer <= timer - 32'd1;
            case (state)
                IDLE: if (ow.cmd_valid) begin
                    op      <= ow.cmd_op;
                    sh      <= ow.cmd_data;
                    bit_cnt <= '0;
                    if (ow.cmd_op == 2'b11) begin
                        state       <= DONE;
                        ow.rsp_valid <= 1'b1;
                        ow.rsp_err  <= 1'b1;
                        ow.rsp_data <= '0;
                    end else begin
                        state           <= ow.cmd_op == 2'b00 ? RST_LOW : SLOT_LOW;
                        ow.bus_pull_low <= 1'b1;
                        timer           <= ow.cmd_op == 2'b00 ? L_RSTL :
                                           (ow.cmd_op == 2'b10 || ow.cmd_data[0]) ? L_LOW1 : L_LOW0;
`ifdef OW_CRC_EN
                        if (ow.cmd_op == 2'b00) ow.crc_out <= '0;
`endif
                    end
                end
                RST_LOW: if (timer == '0) begin
                    state           <= RST_WAIT;
                    timer           <= L_PDS;
                    ow.bus_pull_low <= 1'b0;
                end
                RST_WAIT: if (timer == '0) begin
                    state        <= RST_HOLD;
                    timer        <= L_HOLD;
                    presence_tmp <= ~ow.bus_in;
                end
                RST_HOLD: if (timer == '0) begin
                    state           <= DONE;
                    ow.rsp_valid    <= 1'b1;
                    ow.rsp_presence <= presence_tmp;
                    ow.rsp_data     <= '0;
                    ow.rsp_err      <= 1'b0;
                end
                SLOT_LOW: if (timer == '0) begin
                    state           <= rd_op ? SLOT_SAMP : SLOT_REC;
                    timer           <= rd_op ? L_SAMP : sh[bit_cnt] ? L_REC1 : L_REC0;
                    ow.bus_pull_low <= 1'b0;
`ifdef OW_CRC_EN
                    if (!rd_op) ow.crc_out <= crc_step(ow.crc_out, sh[bit_cnt]);
`endif
                end
                SLOT_SAMP: if (timer == '0) begin
                    state       <= SLOT_REC;
                    timer       <= L_RECRD;
                    sh[bit_cnt] <= ow.bus_in;
`ifdef OW_CRC_EN
                    ow.crc_out  <= crc_step(ow.crc_out, ow.bus_in);
`endif
                end
                SLOT_REC: if (timer == '0) begin
                    bit_cnt <= nxt;
                    if (bit_cnt == 3'd7) begin
                        state        <= DONE;
                        ow.rsp_valid <= 1'b1;
                        ow.rsp_data  <= sh;
                        ow.rsp_err   <= 1'b0;
                    end else begin
                        state           <= SLOT_LOW;
                        ow.bus_pull_low <= 1'b1;
                        timer           <= (rd_op || sh[nxt]) ? L_LOW1 : L_LOW0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_onewire_master_sequencer.sv
// tb_onewire_master_sequencer: random command mix against a slot-timing model with a simulated 1-Wire slave.
// Build with OW_CRC_EN to also check crc_out.
module tb_onewire_master_sequencer;
    localparam int C = 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic model_pres = 1'b0;
    logic [7:0] model_crc = 8'h00;
    always #5 clk = ~clk;
    onewire_master_sequencer_if ow();
    onewire_master_sequencer #(.CLK_PER_US(C)) dut (.clk(clk), .reset(reset), .ow(ow));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? 8'h8C : 8'h00);
    endfunction

    // Expected master pull-low in cycle k after accept (k=1 is the first cycle)
    function automatic logic exp_low(input logic [1:0] op, input logic [7:0] d, input int k);
        int j = (k - 1) / (70 * C);
        int t = (k - 1) % (70 * C);
        if (op == 2'b00) return k <= 480 * C;
        if (op == 2'b11 || j > 7) return 1'b0;
        return t < ((op == 2'b10 || d[j]) ? 6 * C : 60 * C);
    endfunction

    // Simulated slave: presence pulse after reset release, holds bus low for read 0-bits
    function automatic logic slave_low(input logic [1:0] op, input logic pres, input logic [7:0] rd, input int k);
        int j = (k - 1) / (70 * C);
        int t = (k - 1) % (70 * C);
        if (op == 2'b00) return pres && k >= 496 * C && k < 721 * C;
        if (op == 2'b10 && j < 8) return !rd[j] && t < 30 * C;
        return 1'b0;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] rd, input logic pres);
        int lat = op == 2'b00 ? 960 * C + 1 : op == 2'b11 ? 1 : 560 * C + 1;
        int k = 0;
        int bad = 0;
        int busy_bad = 0;
        @(negedge clk);
        check("ready_idle", ow.cmd_ready, 1);
        ow.cmd_valid = 1'b1;
        ow.cmd_op = op;
        ow.cmd_data = d;
        @(posedge clk);
        #1;
        ow.cmd_op = 2'($urandom);
        ow.cmd_data = 8'($urandom);
        ow.cmd_valid = 1'($urandom);
        do begin
            @(negedge clk);
            k++;
            ow.bus_in = !ow.bus_pull_low && !slave_low(op, pres, rd, k);
            if (!ow.rsp_valid) begin
                if (ow.bus_pull_low !== exp_low(op, d, k)) bad++;
                if (ow.cmd_ready || !ow.busy) busy_bad++;
            end
        end while (!ow.rsp_valid && k < lat + 10);
        ow.cmd_valid = 1'b0;
        ow.bus_in = 1'b1;
        if (op == 2'b00) model_pres = pres;
        check("latency", k, lat);
        check("pull_pattern", bad, 0);
        check("ready_while_busy", busy_bad, 0);
        check("ready_at_rsp", ow.cmd_ready, 0);
        check("rsp_err", ow.rsp_err, op == 2'b11);
        check("rsp_data", ow.rsp_data, op == 2'b01 ? d : op == 2'b10 ? rd : 8'h00);
        check("rsp_presence", ow.rsp_presence, model_pres);
`ifdef OW_CRC_EN
        if (op == 2'b00) model_crc = 8'h00;
        else if (op != 2'b11) for (int i = 0; i < 8; i++) model_crc = crc_bit(model_crc, op == 2'b01 ? d[i] : rd[i]);
        check("crc_out", ow.crc_out, model_crc);
`endif
        @(negedge clk);
        check("rsp_one_cycle", {ow.rsp_valid, ow.cmd_ready}, 2'b01);
    endtask

    task automatic abort_cmd(input logic [1:0] op);
        int n = 0;
        @(negedge clk);
        ow.cmd_valid = 1'b1;
        ow.cmd_op = op;
        ow.cmd_data = 8'h00;
        @(posedge clk);
        #1 ow.cmd_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_pre_pull", ow.bus_pull_low, op == 2'b01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_pres = 1'b0;
        model_crc = 8'h00;
        check("abort_pull", ow.bus_pull_low, 0);
        check("abort_ready", {ow.cmd_ready, ow.busy}, 2'b10);
        repeat (600) begin
            @(negedge clk);
            if (ow.rsp_valid) n++;
        end
        check("abort_no_rsp", n, 0);
    endtask

    initial begin
        logic [7:0] rom [8] = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
        ow.cmd_valid = 1'b0;
        ow.cmd_op = 2'b00;
        ow.cmd_data = 8'h00;
        ow.bus_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready_busy", {ow.cmd_ready, ow.busy}, 2'b10);
        check("rst_pull", ow.bus_pull_low, 0);
        check("rst_rsp", {ow.rsp_valid, ow.rsp_presence, ow.rsp_err, ow.rsp_data}, 0);
`ifdef OW_CRC_EN
        check("rst_crc", ow.crc_out, 0);
`endif
        reset = 1'b0;
        run_cmd(2'b00, 8'h00, 8'h00, 1'b1);
        run_cmd(2'b00, 8'h00, 8'h00, 1'b0);
        run_cmd(2'b01, 8'hA5, 8'h00, 1'b0);
        run_cmd(2'b10, 8'h00, 8'hF2, 1'b0);
        run_cmd(2'b11, 8'h5A, 8'h00, 1'b0);
        abort_cmd(2'b10);
        abort_cmd(2'b01);
`ifdef OW_CRC_EN
        run_cmd(2'b00, 8'h00, 8'h00, 1'b1);
        run_cmd(2'b01, 8'h33, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) run_cmd(2'b10, 8'h00, rom[i], 1'b0);
        run_cmd(2'b00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) run_cmd(2'b10, 8'h00, rom[i], 1'b0);
        check("crc_rom_zero", ow.crc_out, 0);
`endif
        repeat (20) run_cmd(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
